// File: rtl/w_schedule_ctrl_if.sv
// Handshake and datapath-control bundle for the SHA-256 message-schedule sequencer.
// The w_hold member only exists when W_SCHED_STALL_EN is defined.
interface w_schedule_ctrl_if #(
    parameter int W_LENGTH  = 64,
    parameter int MSG_WIDTH = 512
);
    localparam int IDX_W = (W_LENGTH > 1) ? $clog2(W_LENGTH) : 1;

    logic                 msg_valid;
    logic [MSG_WIDTH-1:0] msg_data;
    logic                 msg_ready;
    logic                 abort;
    logic                 w_vector_complete;
    logic                 w_enable;
    logic                 w_index_complete;
    logic [IDX_W-1:0]     w_vector_index;
    logic [MSG_WIDTH-1:0] message_vector;
    logic                 w_word_valid;
    logic [IDX_W-1:0]     w_word_index;
    logic                 busy;
    logic                 done;
`ifdef W_SCHED_STALL_EN
    logic                 w_hold;
`endif

    // Upstream padder and W datapath side
    modport master (
`ifdef W_SCHED_STALL_EN
        output w_hold,
`endif
        output msg_valid, msg_data, abort, w_vector_complete,
        input  msg_ready, w_enable, w_index_complete, w_vector_index,
        input  message_vector, w_word_valid, w_word_index, busy, done
    );

    // Sequencer side
    modport slave (
`ifdef W_SCHED_STALL_EN
        input  w_hold,
`endif
        input  msg_valid, msg_data, abort, w_vector_complete,
        output msg_ready, w_enable, w_index_complete, w_vector_index,
        output message_vector, w_word_valid, w_word_index, busy, done
    );
endinterface

// File: rtl/w_schedule_ctrl.sv
// Sequencer for the SHA-256 message-schedule datapath: accept block, step W index, await echo, pulse done.
// Optional feature macro W_SCHED_STALL_EN adds the w_hold input that freezes index advance.
module w_schedule_ctrl #(
    parameter int W_LENGTH  = 64,
    parameter int MSG_WIDTH = 512
) (
    input  logic              clock,
    input  logic              reset_n,
    w_schedule_ctrl_if.slave  bus
);
    localparam int IDX_W = (W_LENGTH > 1) ? $clog2(W_LENGTH) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(W_LENGTH - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_EXPAND = 3'd2,
        S_FLUSH  = 3'd3,
        S_DONE   = 3'd4
    } state_e;

    state_e               state_q, state_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic                 wvld_q, wvld_d;
    logic [IDX_W-1:0]     widx_q, widx_d;
    logic [MSG_WIDTH-1:0] msg_q, msg_d;
    logic                 hold;

`ifdef W_SCHED_STALL_EN
    assign hold = bus.w_hold;
`else
    assign hold = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            wvld_q  <= 1'b0;
            widx_q  <= '0;
            msg_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            wvld_q  <= wvld_d;
            widx_q  <= widx_d;
            msg_q   <= msg_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        wvld_d  = 1'b0;
        widx_d  = widx_q;
        msg_d   = msg_q;
        unique case (state_q)
            S_IDLE: begin
                idx_d = '0;
                if (bus.msg_valid) begin
                    msg_d   = bus.msg_data;
                    state_d = S_LOAD;
                end
            end
            // LOAD and EXPAND both present idx_q; the datapath writes that word on this edge
            S_LOAD, S_EXPAND: begin
                if (!hold) begin
                    wvld_d = 1'b1;
                    widx_d = idx_q;
                    if (idx_q == IDX_LAST) begin
                        state_d = S_FLUSH;
                    end else begin
                        state_d = S_EXPAND;
                        idx_d   = idx_q + IDX_W'(1);
                    end
                end
            end
            S_FLUSH: begin
                if (bus.w_vector_complete) begin
                    state_d = S_DONE;
                    idx_d   = '0;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                idx_d   = '0;
            end
            default: begin
                state_d = S_IDLE;
                idx_d   = '0;
            end
        endcase

        // Abort beats both hold and the complete echo; the latched block is kept
        if (bus.abort && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
            idx_d   = '0;
            wvld_d  = 1'b0;
            widx_d  = widx_q;
        end
    end

    always_comb begin
        bus.msg_ready        = (state_q == S_IDLE);
        bus.w_enable         = (state_q == S_LOAD) || (state_q == S_EXPAND) || (state_q == S_FLUSH);
        bus.w_index_complete = (state_q == S_FLUSH);
        bus.busy             = (state_q != S_IDLE);
        bus.done             = (state_q == S_DONE);
        bus.w_vector_index   = idx_q;
        bus.w_word_valid     = wvld_q;
        bus.w_word_index     = widx_q;
        bus.message_vector   = msg_q;
    end
endmodule

// File: tb/tb_w_schedule_ctrl.sv
// Directed bench for w_schedule_ctrl: block timing, back-to-back, abort, reset in FLUSH, echo delay, stall.
module tb_w_schedule_ctrl;
    logic clock = 1'b0;
    logic reset_n;

    w_schedule_ctrl_if #(.W_LENGTH(64), .MSG_WIDTH(512)) bus ();

    w_schedule_ctrl #(.W_LENGTH(64), .MSG_WIDTH(512)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clock = ~clock;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    int fc    = 0;
    int extra = 0;
    bit force_cpl = 1'b0;
    int seen;

    localparam logic [511:0] ABC = {32'h61626380, 448'h0, 32'h00000018};
    localparam logic [511:0] BLK2 = {16{32'hdeadbeef}};
    localparam logic [511:0] BLK3 = {16{32'ha5a5c3c3}};
    localparam logic [511:0] BLK4 = {16{32'h0f1e2d3c}};
    localparam logic [511:0] BLK5 = {16{32'h12345678}};

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; datapath model echoes complete 1+extra cycles after w_index_complete rises
    task automatic step();
        @(posedge clock);
        #1;
        cyc++;
        if (bus.w_index_complete) fc++;
        else fc = 0;
        bus.w_vector_complete = force_cpl || (bus.w_index_complete && (fc >= 2 + extra));
    endtask

    task automatic set_hold(input bit h);
`ifdef W_SCHED_STALL_EN
        bus.w_hold = h;
`else
        if (h) $display("[TB] hold requested without stall build");
`endif
    endtask

    task automatic start_block(input logic [511:0] d);
        cyc = 0;
        bus.msg_data  = d;
        bus.msg_valid = 1'b1;
        step();
        bus.msg_valid = 1'b0;
    endtask

    task automatic run_to(input int n);
        while (cyc < n) step();
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_ready"}, bus.msg_ready, 1);
        check({tag, "_en"}, bus.w_enable, 0);
        check({tag, "_icmp"}, bus.w_index_complete, 0);
        check({tag, "_busy"}, bus.busy, 0);
        check({tag, "_done"}, bus.done, 0);
        check({tag, "_wvld"}, bus.w_word_valid, 0);
        check({tag, "_idx"}, bus.w_vector_index, 0);
        check({tag, "_widx"}, bus.w_word_index, 0);
        check({tag, "_mv"}, bus.message_vector, 0);
    endtask

    task automatic run_block(input logic [511:0] d, input int ex, input int hs, input int hl,
                             input bit keep, input logic [511:0] nd, input int exp_done,
                             input string tag);
        int done_cyc  = -1;
        int ready_cyc = -1;
        int nstr      = 0;
        bit order_ok  = 1'b1;
        bit mv_ok     = 1'b1;
        bit frz_ok    = 1'b1;
        extra = ex;
        cyc = 0;
        bus.msg_data  = d;
        bus.msg_valid = 1'b1;
        step();
        if (keep) bus.msg_data = nd;
        else bus.msg_valid = 1'b0;
        check({tag, "_c1_en"}, bus.w_enable, 1);
        check({tag, "_c1_idx"}, bus.w_vector_index, 0);
        check({tag, "_c1_mv"}, bus.message_vector, d);
        check({tag, "_c1_ready"}, bus.msg_ready, 0);
        while (ready_cyc < 0 && cyc < 200) begin
            set_hold(hl > 0 && cyc >= hs && cyc < hs + hl);
            if (bus.w_word_valid) begin
                if (bus.w_word_index !== nstr[5:0]) order_ok = 1'b0;
                nstr++;
            end
            if (bus.message_vector !== d) mv_ok = 1'b0;
            if (hl > 0 && cyc >= hs && cyc <= hs + hl && bus.w_vector_index !== 6'(hs - 1))
                frz_ok = 1'b0;
            if (bus.done && done_cyc < 0) done_cyc = cyc;
            if (bus.msg_ready) ready_cyc = cyc;
            else step();
        end
        set_hold(1'b0);
        check({tag, "_done_cycle"}, 512'(done_cyc), 512'(exp_done));
        check({tag, "_ready_cycle"}, 512'(ready_cyc), 512'(exp_done + 1));
        check({tag, "_done_pulse"}, bus.done, 0);
        check({tag, "_strobes"}, 512'(nstr), 512'd64);
        check({tag, "_order"}, order_ok, 1);
        check({tag, "_mv_stable"}, mv_ok, 1);
        if (hl > 0) check({tag, "_idx_frozen"}, frz_ok, 1);
    endtask

    initial begin
        reset_n               = 1'b0;
        bus.msg_valid         = 1'b0;
        bus.msg_data          = '0;
        bus.abort             = 1'b0;
        bus.w_vector_complete = 1'b0;
        set_hold(1'b0);
        step();
        step();
        check_reset_state("rst");
        reset_n = 1'b1;
        step();

        // "abc" block, fixed latency
        run_block(ABC, 0, 0, 0, 1'b0, '0, 67, "abc");

        // Back-to-back with msg_valid held: second accept at the cycle-68 edge
        run_block(ABC, 0, 0, 0, 1'b1, BLK2, 67, "b2b1");
        run_block(BLK2, 0, 0, 0, 1'b0, '0, 67, "b2b2");

        // Stray valid and complete during EXPAND, then abort in cycle 30
        start_block(BLK3);
        run_to(10);
        bus.msg_valid = 1'b1;
        bus.msg_data  = BLK4;
        force_cpl     = 1'b1;
        bus.w_vector_complete = 1'b1;
        run_to(13);
        force_cpl     = 1'b0;
        bus.w_vector_complete = 1'b0;
        bus.msg_valid = 1'b0;
        check("ign_idx", bus.w_vector_index, 12);
        check("ign_icmp", bus.w_index_complete, 0);
        check("ign_mv", bus.message_vector, BLK3);
        check("ign_ready", bus.msg_ready, 0);
        run_to(30);
        check("abt_pre_idx", bus.w_vector_index, 29);
        bus.abort = 1'b1;
        step();
        bus.abort = 1'b0;
        check("abt_ready", bus.msg_ready, 1);
        check("abt_en", bus.w_enable, 0);
        check("abt_busy", bus.busy, 0);
        check("abt_done", bus.done, 0);
        check("abt_wvld", bus.w_word_valid, 0);
        check("abt_idx", bus.w_vector_index, 0);
        check("abt_mv", bus.message_vector, BLK3);
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (bus.done || bus.w_word_valid || bus.busy) seen++;
        end
        check("abt_quiet", 512'(seen), 0);

        // Abort and complete echo in the same FLUSH cycle: abort wins
        extra = 0;
        start_block(BLK4);
        run_to(66);
        check("abf_icmp", bus.w_index_complete, 1);
        check("abf_idx", bus.w_vector_index, 63);
        bus.abort = 1'b1;
        step();
        bus.abort = 1'b0;
        check("abf_done", bus.done, 0);
        check("abf_ready", bus.msg_ready, 1);
        check("abf_en", bus.w_enable, 0);
        check("abf_mv", bus.message_vector, BLK4);

        // Reset during FLUSH, then a normal block
        extra = 5;
        start_block(BLK5);
        run_to(66);
        check("rfl_icmp", bus.w_index_complete, 1);
        reset_n = 1'b0;
        step();
        check_reset_state("rfl");
        reset_n = 1'b1;
        step();
        run_block(ABC, 0, 0, 0, 1'b0, '0, 67, "post_rst");

        // Datapath echo three cycles late
        run_block(BLK2, 3, 0, 0, 1'b0, '0, 70, "late3");

`ifdef W_SCHED_STALL_EN
        // Five hold cycles while index 20 is presented
        run_block(ABC, 0, 21, 5, 1'b0, '0, 72, "stall");
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
